spike_event_decoder: RTL and testbench

Receive-side companion to the Izhikevich neuron core. It samples the neuron's 8-bit signed membrane-voltage output and detects spikes by threshold crossing with hysteresis. For each spike it measures the inter-spike interval (ISI) in sample periods and flags burst-like intervals. Spike records are queued in a 4-entry FIFO behind a valid/ready handshake, so a host or serializer downstream can drain them at its own pace.

---
 rtl/spike_event_decoder.sv | 162 ++++++++++++++++
 tb/tb_spike_event_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_decoder.sv
// Spike detector for the Izhikevich neuron voltage stream: threshold/hysteresis
// detection, inter-spike interval measurement and a 4-deep record FIFO.
module spike_event_decoder #(
   parameter logic signed [7:0] THRESH    = 8'sd16,
   parameter logic signed [7:0] REARM     = -8'sd16,
   parameter int                BURST_ISI = 8,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic signed [7:0] v_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CNT_W-1:0]  out_isi,
   output logic              out_first,
   output logic              out_burst,
   output logic              spike,
   output logic [7:0]        spike_count,
   output logic              overflow
);

   localparam int               DEPTH     = 4;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [31:0]      BURST_LIM = BURST_ISI;

   typedef enum logic {
      ARMED = 1'b0,
      FIRED = 1'b1
   } det_state_t;

   det_state_t       state_reg, state_next;
   logic             spike_sample;

   logic [CNT_W-1:0] cnt_reg;
   logic             first_reg;
   logic             rec_burst;

   logic [1:0]       wr_ptr_reg, rd_ptr_reg;
   logic [2:0]       count_reg;
   logic             fifo_full, push, pop, drop;

   logic [CNT_W-1:0] isi_mem   [DEPTH];
   logic             first_mem [DEPTH];
   logic             burst_mem [DEPTH];

   logic             spike_reg;
   logic [7:0]       spike_count_reg;
   logic             overflow_reg;

   // Detector: a spike is only possible from ARMED; FIRED waits for the re-arm level.
   always_comb begin
      state_next   = state_reg;
      spike_sample = 1'b0;
      if (en) begin
         case (state_reg)
            ARMED: begin
               if (v_in >= THRESH) begin
                  spike_sample = 1'b1;
                  state_next   = FIRED;
               end
            end
            FIRED: begin
               if (v_in <= REARM) begin
                  state_next = ARMED;
               end
            end
            default: state_next = ARMED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ARMED;
      end else begin
         state_reg <= state_next;
      end
   end

   // Interval counter restarts at 1 so the captured value equals the sample-index gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         first_reg <= 1'b1;
      end else if (en) begin
         if (spike_sample) begin
            cnt_reg   <= {{(CNT_W-1){1'b0}}, 1'b1};
            first_reg <= 1'b0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign rec_burst = ~first_reg && (cnt_reg != '0) &&
                      ({{(32-CNT_W){1'b0}}, cnt_reg} <= BURST_LIM);

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign fifo_full = (count_reg == 3'(DEPTH));
   assign pop       = (count_reg != 3'd0) && out_ready;
   assign push      = spike_sample && (~fifo_full || pop);
   assign drop      = spike_sample && fifo_full && ~pop;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == 2'(gi))) begin
               isi_mem[gi]   <= cnt_reg;
               first_mem[gi] <= first_reg;
               burst_mem[gi] <= rec_burst;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 2'd1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 2'd1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spike_reg       <= 1'b0;
         spike_count_reg <= '0;
         overflow_reg    <= 1'b0;
      end else begin
         spike_reg <= spike_sample;
         if (spike_sample) begin
            spike_count_reg <= spike_count_reg + 8'd1;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Head fields are forced to zero when empty so stale entries never leak out.
   assign out_valid   = (count_reg != 3'd0);
   assign out_isi     = out_valid ? isi_mem[rd_ptr_reg]   : '0;
   assign out_first   = out_valid ? first_mem[rd_ptr_reg] : 1'b0;
   assign out_burst   = out_valid ? burst_mem[rd_ptr_reg] : 1'b0;
   assign spike       = spike_reg;
   assign spike_count = spike_count_reg;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_spike_event_decoder.sv
// Randomized and directed bench for spike_event_decoder; two instances (16-bit and
// 4-bit interval counters) share stimulus and are checked against an event-level model.
module tb_spike_event_decoder;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic signed [7:0] v_in = '0;
   logic              out_ready = 1'b0;

   logic        valid0, first0, burst0, spike0, ovf0;
   logic [15:0] isi0;
   logic [7:0]  sc0;
   logic        valid1, first1, burst1, spike1, ovf1;
   logic [3:0]  isi1;
   logic [7:0]  sc1;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per instance, spikes are tracked by sample index.
   int m_isi   [2][4];
   int m_first [2][4];
   int m_burst [2][4];
   int m_n     [2];
   int m_armed [2];
   int m_firstf[2];
   int m_idx   [2];
   int m_last  [2];
   int m_sc    [2];
   int m_ovf   [2];
   int m_spk   [2];

   spike_event_decoder #(.CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .en(en), .v_in(v_in), .out_ready(out_ready),
      .out_valid(valid0), .out_isi(isi0), .out_first(first0), .out_burst(burst0),
      .spike(spike0), .spike_count(sc0), .overflow(ovf0)
   );

   spike_event_decoder #(.CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .en(en), .v_in(v_in), .out_ready(out_ready),
      .out_valid(valid1), .out_isi(isi1), .out_first(first1), .out_burst(burst1),
      .spike(spike1), .spike_count(sc1), .overflow(ovf1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int mx;
         int isi;
         bit pop;
         bit spk;
         mx = (k == 0) ? 65535 : 15;
         if (rst) begin
            m_n[k] = 0; m_armed[k] = 1; m_firstf[k] = 1; m_idx[k] = 0; m_last[k] = 0;
            m_sc[k] = 0; m_ovf[k] = 0; m_spk[k] = 0;
         end else begin
            pop = (m_n[k] > 0) && out_ready;
            spk = en && (m_armed[k] != 0) && (int'(v_in) >= 16);
            if (en) begin
               if (m_armed[k] != 0 && int'(v_in) >= 16) m_armed[k] = 0;
               else if (m_armed[k] == 0 && int'(v_in) <= -16) m_armed[k] = 1;
            end
            m_spk[k] = spk;
            if (pop) begin
               for (int i = 0; i < 3; i++) begin
                  m_isi[k][i] = m_isi[k][i+1];
                  m_first[k][i] = m_first[k][i+1];
                  m_burst[k][i] = m_burst[k][i+1];
               end
               m_n[k]--;
            end
            if (spk) begin
               isi = m_idx[k] - m_last[k];
               if (isi > mx) isi = mx;
               if (m_n[k] < 4) begin
                  m_isi[k][m_n[k]] = isi;
                  m_first[k][m_n[k]] = m_firstf[k];
                  m_burst[k][m_n[k]] = (m_firstf[k] == 0) && (isi <= 8) && (isi != 0);
                  m_n[k]++;
               end else begin
                  m_ovf[k] = 1;
               end
               m_sc[k] = (m_sc[k] + 1) % 256;
               m_firstf[k] = 0;
               m_last[k] = m_idx[k];
            end
            if (en) m_idx[k]++;
         end
      end
   endtask

   task automatic compare();
      chk("valid0", int'(valid0), int'(m_n[0] > 0));
      chk("isi0",   int'(isi0),   (m_n[0] > 0) ? m_isi[0][0] : 0);
      chk("first0", int'(first0), (m_n[0] > 0) ? m_first[0][0] : 0);
      chk("burst0", int'(burst0), (m_n[0] > 0) ? m_burst[0][0] : 0);
      chk("spike0", int'(spike0), m_spk[0]);
      chk("count0", int'(sc0),    m_sc[0]);
      chk("ovf0",   int'(ovf0),   m_ovf[0]);
      chk("valid1", int'(valid1), int'(m_n[1] > 0));
      chk("isi1",   int'(isi1),   (m_n[1] > 0) ? m_isi[1][0] : 0);
      chk("first1", int'(first1), (m_n[1] > 0) ? m_first[1][0] : 0);
      chk("burst1", int'(burst1), (m_n[1] > 0) ? m_burst[1][0] : 0);
      chk("spike1", int'(spike1), m_spk[1]);
      chk("count1", int'(sc1),    m_sc[1]);
      chk("ovf1",   int'(ovf1),   m_ovf[1]);
   endtask

   task automatic step(input logic r, input logic e, input int v, input logic rd);
      rst = r; en = e; v_in = 8'(v); out_ready = rd;
      @(posedge clk);
      model_step();
      #1;
      compare();
      $display("cyc rst=%0b en=%0b v=%0d rdy=%0b -> valid=%0b isi=%0d first=%0b burst=%0b spike=%0b cnt=%0d ovf=%0b",
               r, e, v, rd, valid0, isi0, first0, burst0, spike0, sc0, ovf0);
      @(negedge clk);
   endtask

   // Re-arm sample followed by a spike sample.
   task automatic spike_pair(input logic rd);
      step(1'b0, 1'b1, -32, rd);
      step(1'b0, 1'b1, 20, rd);
   endtask

   task automatic do_reset();
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, 1'b0);
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, 1'b1);
   endtask

   function automatic int rand_v();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(16, 127));
         1:       return -int'($urandom_range(16, 128));
         2:       return int'($urandom_range(0, 30)) - 15;
         default: return int'($urandom_range(0, 255)) - 128;
      endcase
   endfunction

   initial begin
      @(negedge clk);
      // Reset with random inputs, then the first spike at sample 9.
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, -32, 1'b0);
      step(1'b0, 1'b1, 20, 1'b0);
      chk("first_spike_pulse", int'(spike0), 1);
      chk("first_isi", int'(isi0), 9);
      chk("first_flag", int'(first0), 1);
      chk("first_count", int'(sc0), 1);
      step(1'b0, 1'b1, 20, 1'b1);
      chk("spike_one_cycle", int'(spike0), 0);

      // Hysteresis: no re-arm above REARM, then exactly one spike.
      step(1'b0, 1'b1, 18, 1'b1);
      step(1'b0, 1'b1, 0, 1'b1);
      step(1'b0, 1'b1, -10, 1'b1);
      step(1'b0, 1'b1, 20, 1'b1);
      chk("hyst_no_spike", int'(sc0), 1);
      step(1'b0, 1'b1, -20, 1'b1);
      step(1'b0, 1'b1, 20, 1'b1);
      chk("hyst_count", int'(sc0), 2);

      // Burst classification: spikes at en-sample indices 0, 5, 17 with en toggling.
      do_reset();
      for (int s = 0; s <= 17; s++) begin
         step(1'b0, 1'b0, 20, 1'b0);
         step(1'b0, 1'b1, (s == 0 || s == 5 || s == 17) ? 20 : -32, 1'b0);
      end
      step(1'b0, 1'b0, 20, 1'b1);
      chk("burst_isi", int'(isi0), 5);
      chk("burst_flag", int'(burst0), 1);
      step(1'b0, 1'b0, 20, 1'b1);
      chk("nonburst_isi", int'(isi0), 12);
      chk("nonburst_flag", int'(burst0), 0);
      step(1'b0, 1'b0, 20, 1'b1);

      // Backpressure and overflow, then ordered drain.
      do_reset();
      for (int i = 0; i < 5; i++) spike_pair(1'b0);
      chk("ovf_set", int'(ovf0), 1);
      chk("ovf_count", int'(sc0), 5);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, -32, 1'b1);
      chk("drained", int'(valid0), 0);

      // Push while full with a simultaneous pop is accepted.
      do_reset();
      for (int i = 0; i < 4; i++) spike_pair(1'b0);
      step(1'b0, 1'b1, -32, 1'b0);
      step(1'b0, 1'b1, 20, 1'b1);
      chk("full_pushpop_ovf", int'(ovf0), 0);
      chk("full_pushpop_count", int'(sc0), 5);

      // Reset during a drain after an overflow.
      spike_pair(1'b0);
      chk("ovf_before_rst", int'(ovf0), 1);
      step(1'b0, 1'b0, 0, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1);
      chk("rst_valid", int'(valid0), 0);
      chk("rst_ovf", int'(ovf0), 0);

      // Saturation: 20 non-spike samples between spikes.
      do_reset();
      step(1'b0, 1'b1, -32, 1'b0);
      step(1'b0, 1'b1, 20, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, -32, 1'b0);
      step(1'b0, 1'b1, 20, 1'b0);
      step(1'b0, 1'b0, 0, 1'b1);
      chk("sat_isi4", int'(isi1), 15);
      chk("sat_burst4", int'(burst1), 0);
      chk("wide_isi16", int'(isi0), 21);

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
              rand_v(), 1'($urandom_range(0, 2) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
